// File: rtl/wb_node_arbiter_pkg.sv
// Shared definitions for the node Wishbone arbiter: FSM state encoding,
// one-hot grant constants and the default watchdog limit.
package wb_node_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int unsigned WB_NODE_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wb_node_arbiter_wdog.sv
// Transfer watchdog for the node arbiter. Counts cycles where the slave
// strobe is pending without an ack and flags expiry when TIMEOUT is reached.
// Only instantiated when WB_NODE_ARB_WDOG_EN is defined.
module wb_node_wdog
    import wb_node_pkg::*;
#(
    parameter int unsigned TIMEOUT = WB_NODE_TIMEOUT_DEFAULT
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic active_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt;

    // Expiry is judged on the count alone so the suppressed strobe in the
    // expiry cycle cannot mask it.
    assign expire_o = active_i && (cnt == LIMIT);

    // Stall counter with reload on ack, idle or expiry; sticky timeout flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (expire_o) begin
                timeout_o <= 1'b1;
            end
            if (!active_i || ack_i || expire_o) begin
                cnt <= '0;
            end else if (stb_i) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/wb_node_arbiter.sv
// Two-master round-robin Wishbone arbiter with cycle-level locking in front
// of the node register bank. Port 0 is the management SoC, port 1 the LA
// debug master. Optional watchdog enabled by defining WB_NODE_ARB_WDOG_EN.
module wb_node_arbiter
    import wb_node_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = WB_NODE_TIMEOUT_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_node_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_e state;
    logic       last;
    logic       m0_req;
    logic       m1_req;
    logic       s_stb_raw;
    logic       wdog_expire;
    logic       own0;
    logic       own1;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;
    assign own0   = (state == OWN0);
    assign own1   = (state == OWN1);

`ifdef WB_NODE_ARB_WDOG_EN
    wb_node_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .active_i  (own0 | own1),
        .stb_i     (s_stb_raw),
        .ack_i     (s_ack_i),
        .expire_o  (wdog_expire),
        .timeout_o (timeout_o)
    );
`else
    assign wdog_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Ownership FSM: round-robin on ties, owner locked for its whole cyc,
    // always returning through IDLE before the other master is granted.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant_o <= GRANT_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_req && (!m1_req || last)) begin
                        state   <= OWN0;
                        grant_o <= GRANT_M0;
                    end else if (m1_req) begin
                        state   <= OWN1;
                        grant_o <= GRANT_M1;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i || wdog_expire) begin
                        state   <= IDLE;
                        last    <= 1'b0;
                        grant_o <= GRANT_NONE;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i || wdog_expire) begin
                        state   <= IDLE;
                        last    <= 1'b1;
                        grant_o <= GRANT_NONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= GRANT_NONE;
                end
            endcase
        end
    end

    // Slave-side mux driven by the registered owner; all zero when idle.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_raw = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        if (own0) begin
            s_cyc_o   = m0_cyc_i;
            s_stb_raw = m0_stb_i;
            s_we_o    = m0_we_i;
            s_sel_o   = m0_sel_i;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
        end else if (own1) begin
            s_cyc_o   = m1_cyc_i;
            s_stb_raw = m1_stb_i;
            s_we_o    = m1_we_i;
            s_sel_o   = m1_sel_i;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
        end
    end

    assign s_stb_o = s_stb_raw & ~wdog_expire;

    // Terminations routed to the owner only; read data shared while owned.
    always_comb begin
        m0_ack_o = own0 & s_ack_i & ~wdog_expire;
        m1_ack_o = own1 & s_ack_i & ~wdog_expire;
        m0_err_o = own0 & wdog_expire;
        m1_err_o = own1 & wdog_expire;
        m0_dat_o = (own0 | own1) ? s_dat_i : '0;
        m1_dat_o = (own0 | own1) ? s_dat_i : '0;
    end

endmodule

// File: tb/tb_wb_node_arbiter.sv
// Directed bench for wb_node_arbiter: arbitration, locking, readback,
// watchdog (either build) and asynchronous reset.
module tb_wb_node_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [DW/8-1:0] m0_sel = '0;
    logic [AW-1:0]   m0_adr = '0;
    logic [DW-1:0]   m0_wdat = '0;
    logic            m0_ack, m0_err;
    logic [DW-1:0]   m0_rdat;
    logic            m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [DW/8-1:0] m1_sel = '0;
    logic [AW-1:0]   m1_adr = '0;
    logic [DW-1:0]   m1_wdat = '0;
    logic            m1_ack, m1_err;
    logic [DW-1:0]   m1_rdat;
    logic            s_cyc, s_stb, s_we;
    logic [DW/8-1:0] s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic            s_ack;
    logic [DW-1:0]   s_rdat = '0;
    logic [1:0]      grant;
    logic            timeout;
    logic            ack_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_ack  = 0;
    logic saw_err;

    assign s_ack = ack_en & s_stb;

    always #5 clk = ~clk;

    wb_node_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_sel_i  (m0_sel),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_wdat),
        .m0_ack_o  (m0_ack),
        .m0_err_o  (m0_err),
        .m0_dat_o  (m0_rdat),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_sel_i  (m1_sel),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_wdat),
        .m1_ack_o  (m1_ack),
        .m1_err_o  (m1_err),
        .m1_dat_o  (m1_rdat),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_rdat),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_scyc", 32'(s_cyc), 32'd0);
        chk("rst_sstb", 32'(s_stb), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_m0dat", m0_rdat, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Tie after reset: m0 wins, m1 follows one idle cycle later
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0010;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0008; m1_we = 0; m1_sel = 4'hF;
        #1;
        chk("tie1_latency", 32'(grant), 32'd0);
        step();
        chk("tie1_grant_m0", 32'(grant), 32'd1);
        chk("tie1_sadr", s_adr, 32'h3000_0010);
        ack_en = 1; #1;
        chk("tie1_m0_ack", 32'(m0_ack), 32'd1);
        chk("tie1_m1_noack", 32'(m1_ack), 32'd0);
        step();
        m0_cyc = 0; m0_stb = 0; ack_en = 0;
        step();
        chk("tie1_idle", 32'(grant), 32'd0);
        step();
        chk("tie1_grant_m1", 32'(grant), 32'd2);
        // Readback by m1
        s_rdat = 32'h0000_00A5; ack_en = 1; #1;
        chk("rd_m1_ack", 32'(m1_ack), 32'd1);
        chk("rd_m1_dat", m1_rdat, 32'h0000_00A5);
        chk("rd_m0_noack", 32'(m0_ack), 32'd0);
        chk("rd_swe", 32'(s_we), 32'd0);
        step();
        m1_cyc = 0; m1_stb = 0; ack_en = 0; s_rdat = '0;
        step();
        chk("rd_idle", 32'(grant), 32'd0);

        // Single master write by m0
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
        m0_adr = 32'h3000_0004; m0_wdat = 32'hDEAD_BEEF;
        step();
        chk("wr_grant", 32'(grant), 32'd1);
        chk("wr_sdat", s_wdat, 32'hDEAD_BEEF);
        chk("wr_sadr", s_adr, 32'h3000_0004);
        chk("wr_swe", 32'(s_we), 32'd1);
        chk("wr_ssel", 32'(s_sel), 32'hF);
        ack_en = 1; #1;
        chk("wr_m0_ack", 32'(m0_ack), 32'd1);
        chk("wr_m1_noack", 32'(m1_ack), 32'd0);
        step();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; ack_en = 0; #1;
        chk("wr_ack_pulse", 32'(m0_ack), 32'd0);
        step();
        chk("wr_idle", 32'(grant), 32'd0);

        // Repeated tie: m0 won last, so m1 goes first
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step();
        chk("tie2_grant_m1", 32'(grant), 32'd2);
        ack_en = 1; #1;
        chk("tie2_m1_ack", 32'(m1_ack), 32'd1);
        chk("tie2_m0_noack", 32'(m0_ack), 32'd0);
        step();
        m1_cyc = 0; m1_stb = 0; ack_en = 0;
        step();
        chk("tie2_idle", 32'(grant), 32'd0);
        step();
        chk("tie2_grant_m0", 32'(grant), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        step();
        chk("tie2_idle2", 32'(grant), 32'd0);

        // Lock: m0 keeps cyc for 4 strobes while m1 requests
        m0_cyc = 1; m0_stb = 1;
        step();
        m1_cyc = 1; m1_stb = 1; ack_en = 1;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (m0_ack) n_ack++;
            chk("lock_m1_noack", 32'(m1_ack), 32'd0);
            chk("lock_grant", 32'(grant), 32'd1);
            step();
        end
        chk("lock_m0_acks", 32'(n_ack), 32'd4);
        m0_cyc = 0; m0_stb = 0; ack_en = 0;
        step();
        chk("lock_release_idle", 32'(grant), 32'd0);
        step();
        chk("lock_m1_grant", 32'(grant), 32'd2);
        m1_cyc = 0; m1_stb = 0;
        step();
        chk("lock_idle", 32'(grant), 32'd0);

        // Watchdog
        m0_cyc = 1; m0_stb = 1; ack_en = 0;
        step();
        chk("wd_grant", 32'(grant), 32'd1);
`ifdef WB_NODE_ARB_WDOG_EN
        saw_err = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (m0_err) saw_err = 1'b1;
        end
        chk("wd_no_early_err", 32'(saw_err), 32'd0);
        chk("wd_stb_before", 32'(s_stb), 32'd1);
        step();
        chk("wd_err_pulse", 32'(m0_err), 32'd1);
        chk("wd_stb_supp", 32'(s_stb), 32'd0);
        chk("wd_m1_noerr", 32'(m1_err), 32'd0);
        m0_cyc = 0; m0_stb = 0;
        step();
        chk("wd_err_done", 32'(m0_err), 32'd0);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_idle", 32'(grant), 32'd0);
`else
        saw_err = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (m0_err || timeout) saw_err = 1'b1;
        end
        chk("wd_off_no_err", 32'(saw_err), 32'd0);
        chk("wd_off_still_own", 32'(grant), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        step();
        chk("wd_off_idle", 32'(grant), 32'd0);
`endif

        // Reset while m1 waits for an ack
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_000C;
        step();
        chk("rmo_grant", 32'(grant), 32'd2);
        step();
        chk("rmo_sstb", 32'(s_stb), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmo_grant0", 32'(grant), 32'd0);
        chk("rmo_scyc", 32'(s_cyc), 32'd0);
        chk("rmo_sstb0", 32'(s_stb), 32'd0);
        chk("rmo_sadr", s_adr, 32'd0);
        chk("rmo_m1ack", 32'(m1_ack), 32'd0);
        chk("rmo_timeout", 32'(timeout), 32'd0);
        step();
        chk("rmo_hold", 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_node_arbiter.md
# wb_node_arbiter

Two-master Wishbone arbiter in front of the user-project node register bank. The Caravel management SoC (port 0) and the logic-analyzer-driven debug master (port 1) share the single internal Wishbone slave. Arbitration is round-robin with cycle-level locking, so a master keeps the bus for a whole `cyc` burst. An optional watchdog terminates stalled transfers with an error.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width; select width is `DW/8`.
- `TIMEOUT`, 255: watchdog limit in cycles; 8-bit counter; legal range 1..255.

Ports:
- `wb_clk_i`  in  1: single clock.
- `wb_rst_i`  in  1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each: master 0 (management SoC) controls.
- `m0_sel_i`  in  DW/8: master 0 byte selects.
- `m0_adr_i`  in  AW: master 0 address.
- `m0_dat_i`  in  DW: master 0 write data.
- `m0_ack_o`, `m0_err_o`  out  1 each: master 0 termination.
- `m0_dat_o`  out  DW: master 0 read data.
- `m1_*`: same set for master 1 (LA debug master).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each: slave-side controls.
- `s_sel_o`  out  DW/8; `s_adr_o`  out  AW; `s_dat_o`  out  DW: slave-side selects, address and write data.
- `s_ack_i`  in  1: slave acknowledge.
- `s_dat_i`  in  DW: slave read data.
- `grant_o`  out  2: one-hot owner; 00 when idle.
- `timeout_o`  out  1: sticky watchdog flag; cleared only by reset.

## Operation
- State machine:
  - `IDLE`: no owner.
  - `OWN0`: master 0 owns the slave.
  - `OWN1`: master 1 owns the slave.
- Request: `mN_req = mN_cyc_i & mN_stb_i`.
- In `IDLE`, only one request: go to that master's `OWNn`.
- In `IDLE`, both requests: grant the master that did not win last. The `last` register resets to 1, so master 0 wins the first tie.
- In `OWNn`, stay while `mN_cyc_i` is high. This locks the bus across back-to-back strobes.
- In `OWNn`, `mN_cyc_i` low: go to `IDLE` and record `last = n`. A request pending on the other master is granted on the next cycle; there is no same-cycle handover.
- Slave outputs mux the owner's `cyc`/`stb`/`we`/`sel`/`adr`/`dat`. In `IDLE`, `s_cyc_o` and `s_stb_o` are 0 and the other slave outputs are 0.
- `s_ack_i` goes only to the owner's `ack`; the non-owner's `ack` and `err` stay 0. `s_dat_i` goes to both `mN_dat_o`.
- The non-owner master is stalled: it gets no ack until it is granted.
- Reset mid-transfer: all state and outputs return to reset values immediately. The master sees its cycle abandoned with no ack.
- Reset values: `grant_o`=00, `timeout_o`=0, all `s_*`=0, all `mN_ack_o`/`mN_err_o`=0, all `mN_dat_o`=0 in `IDLE`.

## Timing
- Arbitration latency is one cycle. A request sampled at edge N makes `grant_o` and `s_stb_o` valid after edge N.
- `ack`, `err` and `dat_o` to the owner are combinational from `s_ack_i`/`s_dat_i`: zero added latency.
- Minimum single access through an idle arbiter is 2 cycles (grant + slave ack). Back-to-back strobes inside a locked cycle run at the slave's rate.
- `s_*` outputs never glitch between owners: ownership changes only on a clock edge, after passing through `IDLE`.

## Configuration
- Macro `WB_NODE_ARB_WDOG_EN`.
- Defined:
  - An 8-bit counter runs while `s_stb_o & ~s_ack_i`, and reloads to 0 on ack or on owner change.
  - When the count reaches `TIMEOUT`, the owner's `err` is pulsed for one cycle and `s_stb_o` is suppressed that cycle.
  - `timeout_o` is set and the state goes to `IDLE`.
- Not defined:
  - No counter; `mN_err_o` and `timeout_o` are tied 0.
  - A stalled slave hangs the owner indefinitely.

## Structure
- A shared package `wb_node_pkg` holds:
  - the state encoding (`IDLE`=0, `OWN0`=1, `OWN1`=2);
  - the grant one-hot constants;
  - the default `TIMEOUT`.
- One sub-module, `wb_node_wdog`, holds the watchdog counter and pulse logic. It is instantiated only under `WB_NODE_ARB_WDOG_EN`.
- The top level holds the FSM, the `last` register and the muxes.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x3000_0004, and the slave acks on its first strobe cycle. Expect `grant_o`=01 one cycle after the request, one `m0_ack_o` pulse, `grant_o`=00 after `cyc` drops, and `m1_ack_o` never set.
- Tie after reset: m0 and m1 request in the same cycle. Expect m0 granted first and m1 granted 1 cycle after m0 drops `cyc`. Repeat the tie and expect m1 granted first.
- Lock: m0 holds `cyc` for 4 strobes while m1 requests throughout. Expect 4 m0 acks, no m1 ack, and m1 granted only after m0's `cyc` falls.
- Readback: m1 reads 0x3000_0008 and the slave returns 0x0000_00A5. Expect `m1_dat_o`=0x0000_00A5 in the same cycle as `m1_ack_o`.
- Watchdog (macro defined, `TIMEOUT`=16): the slave never acks. Expect `m0_err_o` for one cycle 16 cycles after `s_stb_o` rises, then `timeout_o`=1 and `grant_o`=00. With the macro undefined, expect no err after 1000 cycles.
- Reset mid-op: assert `wb_rst_i` while `OWN1` is waiting for ack. Expect all outputs 0 without waiting for a clock edge, and `timeout_o`=0.
